display_scanner: RTL and testbench
==================================

DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter SCAN_DIV, 50000, clock cycles per digit period; legal range 4..65535.
REQ-002 Parameter DEAD, 8, blanking cycles at the start of each digit period; legal range 1..SCAN_DIV-1.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 load  in  1  one-cycle strobe requesting capture of data_in/blank_in.
REQ-006 data_in  in  16  four 4-bit digit codes; digit0 in [3:0], digit3 in [15:12].
REQ-007 blank_in  in  4  per-digit blank; bit i = 1 keeps digit i dark.
REQ-008 busy  out  1  a captured load is pending and not yet committed.
REQ-009 q  out  4  code of the currently scanned digit, to the segment decoder.
REQ-010 dig_n  out  4  active-low digit enables; at most one bit low.
REQ-011 frame  out  1  one-cycle pulse marking the first cycle of a new frame.

Function
REQ-012 Prescaler cnt SHALL count 0..SCAN_DIV-1, wrap to 0; "tick" = cycle with cnt == SCAN_DIV-1.
REQ-013 Digit index idx SHALL advance on each tick edge, 0->1->2->3->0.
REQ-014 "Wrap" SHALL be the tick edge where idx goes 3->0; one frame = 4*SCAN_DIV cycles.
REQ-015 frame SHALL be 1 only in the cycle with idx == 0 and cnt == 0 following a wrap, else 0.
REQ-016 q SHALL equal active code[idx] in every cycle, whether or not the digit is blanked or in dead time.
REQ-017 dig_n SHALL be 4'b1111 while cnt < DEAD, or while active blank[idx] == 1.
REQ-018 Otherwise dig_n SHALL be all-high except bit idx, which is 0.
REQ-019 q, dig_n and frame SHALL be registered, aligned with the registered cnt/idx of the same cycle.
REQ-020 Load FSM states: IDLE (busy=0), PENDING (busy=1).
REQ-021 IDLE + load=1: capture data_in/blank_in into shadow registers; go PENDING; busy=1 next cycle.
REQ-022 PENDING + wrap: copy shadow into active registers at the wrap edge; go IDLE; busy=0 in the frame-pulse cycle.
REQ-023 PENDING + load=1: load SHALL be ignored; shadow unchanged (including the wrap cycle itself).
REQ-024 IDLE + load=1 in a tick or wrap cycle: captured; commit only at the next wrap after capture, never the same edge.
REQ-025 New data SHALL first appear at digit0 of a frame; no frame SHALL mix old and new codes (no tearing).
REQ-026 Scan timing SHALL be independent of load activity; cnt/idx never stall or restart except on reset.

Reset
REQ-027 rst_n low SHALL immediately force cnt=0, idx=0, FSM=IDLE, busy=0, frame=0, q=4'h0, dig_n=4'b1111.
REQ-028 Reset SHALL clear active and shadow codes to 4'h0 and set active and shadow blank to 4'b1111 (display dark until first commit).
REQ-029 Reset mid-operation SHALL discard any pending load; first rising edge after release starts at cnt=0, idx=0.

Structure
REQ-030 Shared package display_pkg SHALL hold N_DIGITS=4, CODE_W=4, DIG_OFF=4'b1111 and the IDLE/PENDING state encoding.
REQ-031 Tick generation SHALL be one sub-module, scan_prescaler (params SCAN_DIV; outputs cnt, tick); all else in display_scanner.

Verification (SCAN_DIV=10, DEAD=2)
REQ-032 Reset release, no load -> dig_n=1111, q=0, busy=0 for 100 cycles; frame pulses every 40 cycles.
REQ-033 load, data_in=16'h4321, blank_in=0000 -> busy=1 next cycle; at wrap busy=0, frame=1; digit0: cnt 0-1 dig_n=1111, cnt 2-9 dig_n=1110, q=1; then 1101/q=2, 1011/q=3, 0111/q=4.
REQ-034 Second load of 16'hFFFF while busy=1 -> ignored; after commit q sequence still 1,2,3,4.
REQ-035 Committed blank_in=0100 -> digit2 period dig_n=1111 for all 10 cycles with q=3; other digits unaffected.
REQ-036 Load with busy=0 exactly in a wrap cycle -> no commit at that wrap; commit at the following wrap, 40 cycles later.
REQ-037 rst_n low mid-digit2 with load pending -> dig_n=1111 and busy=0 without waiting for clk; after release display dark, idx restarts at 0.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg
//   Shared definitions for the multiplexed display scanner: digit count,
//   code width, the all-dark digit-enable pattern, the load FSM state
//   encoding and a helper that builds an active-low one-hot digit enable.
package display_pkg;

  localparam int N_DIGITS = 4;
  localparam int CODE_W   = 4;

  localparam logic [N_DIGITS-1:0] DIG_OFF = 4'b1111;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } load_state_t;

  // All enables high except the selected digit, which is pulled low.
  function automatic logic [N_DIGITS-1:0] digit_enable(input logic [1:0] idx);
    logic [N_DIGITS-1:0] en;
    en      = DIG_OFF;
    en[idx] = 1'b0;
    return en;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// scan_prescaler
//   Free-running divider that sets the length of one digit period.
//   Ports:
//     clk   - system clock, rising edge
//     rst_n - asynchronous active-low reset, clears the count
//     cnt   - current count, 0..SCAN_DIV-1
//     tick  - high in the last cycle of a digit period (cnt == SCAN_DIV-1)
module scan_prescaler #(
  parameter int SCAN_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [$clog2(SCAN_DIV)-1:0] cnt,
  output logic                        tick
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  assign tick = (cnt == CNT_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// display_scanner
//   Time-multiplexes four digit codes onto a shared segment-decoder bus.
//   New codes are staged in shadow registers and only committed at a frame
//   boundary so a single frame never shows a mix of old and new digits.
//   Ports:
//     clk      - system clock, rising edge
//     rst_n    - asynchronous active-low reset
//     load     - one-cycle strobe: capture data_in/blank_in (ignored if busy)
//     data_in  - four 4-bit codes, digit0 in [3:0] .. digit3 in [15:12]
//     blank_in - per-digit blank, bit i = 1 keeps digit i dark
//     busy     - a captured load is waiting for the next frame boundary
//     q        - code of the digit currently being scanned
//     dig_n    - active-low digit enables, at most one low
//     frame    - one-cycle pulse on the first cycle of a new frame
module display_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic [N_DIGITS*CODE_W-1:0] data_in,
  input  logic [N_DIGITS-1:0]        blank_in,
  output logic                       busy,
  output logic [CODE_W-1:0]          q,
  output logic [N_DIGITS-1:0]        dig_n,
  output logic                       frame
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             tick;
  logic             wrap;
  logic [1:0]       idx;
  logic [1:0]       idx_next;

  load_state_t state;
  load_state_t state_next;
  logic        capture;
  logic        commit;

  logic [N_DIGITS-1:0][CODE_W-1:0] active_code;
  logic [N_DIGITS-1:0][CODE_W-1:0] shadow_code;
  logic [N_DIGITS-1:0][CODE_W-1:0] active_code_next;
  logic [N_DIGITS-1:0]             active_blank;
  logic [N_DIGITS-1:0]             shadow_blank;
  logic [N_DIGITS-1:0]             active_blank_next;

  scan_prescaler #(
    .SCAN_DIV(SCAN_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .cnt  (cnt),
    .tick (tick)
  );

  // The outputs are registered but must line up with cnt/idx of the same
  // cycle, so they are computed from the values cnt/idx are about to take.
  always_comb begin
    cnt_next = tick ? '0 : cnt + 1'b1;
    idx_next = tick ? idx + 2'd1 : idx;
    wrap     = tick && (idx == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= 2'd0;
    end else begin
      idx <= idx_next;
    end
  end

  // A load arriving in IDLE during a wrap cycle is only captured here; the
  // commit waits for the following wrap because commit requires PENDING.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture    = 1'b1;
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (wrap) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign busy = (state == PENDING);

  always_comb begin
    active_code_next  = commit ? shadow_code  : active_code;
    active_blank_next = commit ? shadow_blank : active_blank;
  end

  // Reset leaves every digit blanked so the display stays dark until the
  // first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_code  <= '0;
      shadow_blank <= DIG_OFF;
      active_code  <= '0;
      active_blank <= DIG_OFF;
    end else begin
      if (capture) begin
        shadow_code  <= data_in;
        shadow_blank <= blank_in;
      end
      active_code  <= active_code_next;
      active_blank <= active_blank_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      dig_n <= DIG_OFF;
      frame <= 1'b0;
    end else begin
      q <= active_code_next[idx_next];
      if ((cnt_next < CNT_W'(DEAD)) || active_blank_next[idx_next]) begin
        dig_n <= DIG_OFF;
      end else begin
        dig_n <= digit_enable(idx_next);
      end
      frame <= wrap;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// tb_display_scanner
//   Scoreboard bench for display_scanner with SCAN_DIV=10, DEAD=2.
//   Cycle t counts rising edges since reset release, so in cycle t the
//   scanner sits at cnt = t%10, idx = (t/10)%4 and a frame is 40 cycles.
//   Expected per-cycle outputs are queued with their cycle number; a monitor
//   samples on the falling edge and compares against the queue head.
module tb_display_scanner;

  localparam int SCAN_DIV = 10;
  localparam int DEAD     = 2;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic        busy;
  logic [3:0]  q;
  logic [3:0]  dig_n;
  logic        frame;

  int tests_run;
  int tests_failed;
  int cycle;

  typedef struct {
    int         t;
    logic [3:0] q;
    logic [3:0] dig_n;
    logic       frame;
    logic       busy;
  } exp_t;

  exp_t sb[$];

  display_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEAD    (DEAD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (data_in),
    .blank_in(blank_in),
    .busy    (busy),
    .q       (q),
    .dig_n   (dig_n),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle <= 0;
    else        cycle <= cycle + 1;
  end

  // Expected display for cycles t_from..t_to showing the given committed
  // code/blank; busy is expected high for cycles busy_from..busy_to.
  task automatic push_span(input int t_from, input int t_to,
                           input logic [15:0] code, input logic [3:0] blank,
                           input int busy_from, input int busy_to);
    for (int t = t_from; t <= t_to; t++) begin
      exp_t e;
      int   i;
      int   n;
      i       = (t / 10) % 4;
      n       = t % 10;
      e.t     = t;
      e.q     = code[i*4 +: 4];
      e.dig_n = 4'b1111;
      if (n >= DEAD && !blank[i]) e.dig_n[i] = 1'b0;
      e.frame = (t % 40 == 0) && (t > 0);
      e.busy  = (t >= busy_from) && (t <= busy_to);
      sb.push_back(e);
    end
  endtask

  // Monitor: one comparison per queued cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].t < cycle) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL missed t=%0d: not sampled, now at cycle %0d", sb[0].t, cycle);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].t == cycle) begin
        exp_t e;
        e = sb.pop_front();
        tests_run++;
        if (q !== e.q || dig_n !== e.dig_n || frame !== e.frame || busy !== e.busy) begin
          tests_failed++;
          $display("[TB] FAIL scan t=%0d: got q=%h dig_n=%b frame=%b busy=%b, expected q=%h dig_n=%b frame=%b busy=%b",
                   e.t, q, dig_n, frame, busy, e.q, e.dig_n, e.frame, e.busy);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [3:0] got_q,
                              input logic [3:0] got_dig_n, input logic got_busy,
                              input logic got_frame);
    tests_run++;
    if (got_q !== 4'h0 || got_dig_n !== 4'b1111 || got_busy !== 1'b0 || got_frame !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s: got q=%h dig_n=%b busy=%b frame=%b, expected q=0 dig_n=1111 busy=0 frame=0",
               name, got_q, got_dig_n, got_busy, got_frame);
    end
  endtask

  task automatic wait_for_cycle(input int n);
    int guard;
    guard = 0;
    while (cycle != n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (cycle != n) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL wait: got cycle %0d, expected %0d", cycle, n);
    end
  endtask

  // Pulses load for exactly one cycle, launched in cycle t.
  task automatic apply_stimulus(input int t, input logic [15:0] code,
                                input logic [3:0] blank);
    wait_for_cycle(t);
    load     = 1'b1;
    data_in  = code;
    blank_in = blank;
    wait_for_cycle(t + 1);
    load     = 1'b0;
    data_in  = 16'h0000;
    blank_in = 4'b0000;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    load         = 1'b0;
    data_in      = 16'h0000;
    blank_in     = 4'b0000;
    #12;
    rst_n = 1'b1;

    // Dark display after reset, then a load of 4321 that is still dark while
    // pending; a second load (FFFF) during busy must be ignored.
    push_span(1, 159, 16'h0000, 4'b1111, 126, 159);
    apply_stimulus(125, 16'h4321, 4'b0000);
    apply_stimulus(140, 16'hFFFF, 4'b1111);

    // Committed 4321 at t=160; stage a blank of digit2.
    push_span(160, 199, 16'h4321, 4'b0000, 171, 199);
    apply_stimulus(170, 16'h4321, 4'b0100);

    // Digit2 dark from t=200; a load in the wrap cycle t=239 must not commit
    // at t=240 but at t=280.
    push_span(200, 239, 16'h4321, 4'b0100, -1, -1);
    push_span(240, 279, 16'h4321, 4'b0100, 240, 279);
    apply_stimulus(239, 16'h8765, 4'b0000);

    push_span(280, 345, 16'h8765, 4'b0000, 331, 345);
    apply_stimulus(330, 16'hABCD, 4'b0000);

    // Asynchronous reset in the middle of digit2 with a load pending.
    wait_for_cycle(345);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", q, dig_n, busy, frame);
    repeat (2) @(posedge clk);
    #1;
    check_output("held_reset", q, dig_n, busy, frame);
    #1;
    rst_n = 1'b1;

    // Pending ABCD was discarded: display stays dark, idx restarts at 0.
    push_span(1, 85, 16'h0000, 4'b1111, -1, -1);
    wait_for_cycle(85);
    #2;

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: got %0d unchecked entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
